// File: rtl/bitutils.sv
// bitutils: shared bit-level types for the execute units.
//   word_t   - 32-bit architectural word
//   dword_t  - 64-bit double word (full carry-less product)
//   zbc_op_t - Zbc op select: CLMUL=0, CLMULH=1, CLMULR=2, 3 reserved
package bitutils;

    typedef logic [31:0] word_t;
    typedef logic [63:0] dword_t;

    typedef enum logic [1:0] {
        CLMUL   = 2'd0,
        CLMULH  = 2'd1,
        CLMULR  = 2'd2,
        OP_RSVD = 2'd3
    } zbc_op_t;

endpackage

// File: rtl/clmul32.sv
// clmul32: registered 32x32 carry-less (GF(2)) multiplier, 1-cycle latency.
// No reset: the output is only consumed when the owning unit says it is valid.
//   CLK - clock
//   a,b - operands
//   p   - a (x) b, registered
module clmul32
    import bitutils::*;
(
    input  logic   CLK,
    input  word_t  a,
    input  word_t  b,
    output dword_t p
);

    dword_t [31:0] pp;
    dword_t        acc;

    // One shifted partial product per multiplier bit.
    for (genvar i = 0; i < 32; i++) begin : g_pp
        assign pp[i] = b[i] ? (dword_t'(a) << i) : '0;
    end

    // XOR reduction instead of addition: no carries in GF(2).
    always_comb begin
        acc = '0;
        for (int i = 0; i < 32; i++) acc = acc ^ pp[i];
    end

    always_ff @(posedge CLK) p <= acc;

endmodule

// File: rtl/zbc_clmul_unit.sv
// zbc_clmul_unit: multi-cycle execute unit for RISC-V Zbc CLMUL/CLMULH/CLMULR.
// Optional macro ZBC_ZERO_SHORTCUT_EN: a zero operand skips the multiply
// cycle and returns 0 with 1-cycle latency.
// Ports:
//   CLK, nRST           - clock, async active-low reset
//   flush               - kill in-flight op, drop pending result
//   in_valid/in_ready   - request handshake; in_op/in_rs1/in_rs2/in_tag payload
//   out_valid/out_ready - result handshake; out_data/out_tag payload
//   busy                - FSM not idle
module zbc_clmul_unit
    import bitutils::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  zbc_op_t          in_op,
    input  word_t            in_rs1,
    input  word_t            in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output word_t            out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t           state, state_nxt, acc_state;
    zbc_op_t          op_q;
    word_t            a_q, b_q;
    logic [TAG_W-1:0] tag_q;
    dword_t           prod;
    logic             accept;

    function automatic word_t sel_slice(zbc_op_t op, dword_t p);
        case (op)
            CLMUL:   return p[31:0];
            CLMULH:  return p[63:32];
            CLMULR:  return p[62:31];
            default: return '0;
        endcase
    endfunction

    // Multiplier sees only the latched operands, so its output stays frozen
    // while a result waits under backpressure.
    clmul32 u_clmul (
        .CLK (CLK),
        .a   (a_q),
        .b   (b_q),
        .p   (prod)
    );

    assign in_ready = ~flush & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept   = in_valid & in_ready;

`ifdef ZBC_ZERO_SHORTCUT_EN
    logic zero_q, in_zero;
    assign in_zero   = (in_rs1 == '0) | (in_rs2 == '0);
    assign acc_state = in_zero ? DONE : MUL;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)       zero_q <= 1'b0;
        else if (accept) zero_q <= in_zero;
    end
`else
    assign acc_state = MUL;
`endif

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = acc_state;
                MUL:     state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = accept ? acc_state : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            op_q  <= CLMUL;
            a_q   <= '0;
            b_q   <= '0;
            tag_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= in_op;
                a_q   <= in_rs1;
                b_q   <= in_rs2;
                tag_q <= in_tag;
            end
        end
    end

    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_tag   = out_valid ? tag_q : '0;

`ifdef ZBC_ZERO_SHORTCUT_EN
    assign out_data = (out_valid & ~zero_q) ? sel_slice(op_q, prod) : '0;
`else
    assign out_data = out_valid ? sel_slice(op_q, prod) : '0;
`endif

endmodule

// File: tb/tb_zbc_clmul_unit.sv
module tb_zbc_clmul_unit;
    import bitutils::*;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    zbc_op_t     in_op = CLMUL;
    word_t       in_rs1 = '0;
    word_t       in_rs2 = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    word_t       out_data;
    logic [4:0]  out_tag;
    logic        busy;

    int total = 0;
    int bad = 0;

    zbc_clmul_unit #(.TAG_W(5)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one request for one edge; afterwards the unit is in MUL.
    task automatic issue(input zbc_op_t op, input word_t a, input word_t b, input logic [4:0] t);
        in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = t;
        tick();
        in_valid = 1'b0;
    endtask

    // Full op with idle writeback: check MUL cycle, DONE result, then retire.
    task automatic run_op(input string nm, input zbc_op_t op, input word_t a, input word_t b,
                          input logic [4:0] t, input word_t exp);
        issue(op, a, b, t);
        chk({nm, "_mul_valid"}, 32'(out_valid), 32'd0);
        tick();
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_data"}, out_data, exp);
        chk({nm, "_tag"}, 32'(out_tag), 32'(t));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, "_retired"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset held: outputs at reset values.
        tick(); tick();
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        tick(); tick(); tick();
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_data", out_data, 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Basic CLMUL: (x+1)^2 = x^2+1 in GF(2).
        run_op("clmul33", CLMUL, 32'h3, 32'h3, 5'd7, 32'h0000_0005);

        // x^31 * x^31 = x^62: each slice picks a different bit of it.
        run_op("hi_h", CLMULH, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
        run_op("hi_r", CLMULR, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h8000_0000);
        run_op("hi_l", CLMUL,  32'h8000_0000, 32'h8000_0000, 5'd3, 32'h0000_0000);

        // Shift by 4: product 0x1_2345_6780.
        run_op("sh_l", CLMUL,  32'h1234_5678, 32'h10, 5'd4, 32'h2345_6780);
        run_op("sh_h", CLMULH, 32'h1234_5678, 32'h10, 5'd5, 32'h0000_0001);
        run_op("sh_r", CLMULR, 32'h1234_5678, 32'h10, 5'd6, 32'h0000_0002);
        run_op("rsvd", OP_RSVD, 32'h1234_5678, 32'h10, 5'd8, 32'h0000_0000);

        // Backpressure: result held for 5 cycles.
        issue(CLMUL, 32'h3, 32'h5, 5'd9);    // 3 (x) 5 = 0xF
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", out_data, 32'h0000_000F);
            chk("bp_tag", 32'(out_tag), 32'd9);
            chk("bp_ready", 32'(in_ready), 32'd0);
            tick();
        end
        // Back-to-back: consume and accept in the same cycle.
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = CLMUL; in_rs1 = 32'h7; in_rs2 = 32'h3; in_tag = 5'd10;
        #1;
        chk("b2b_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_mul_valid", 32'(out_valid), 32'd0);
        chk("b2b_mul_busy", 32'(busy), 32'd1);
        tick();
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_data", out_data, 32'h0000_0009);   // 0b111 (x) 0b11 = 0b1001
        chk("b2b_tag", 32'(out_tag), 32'd10);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Flush during MUL, with a competing request that must be refused.
        issue(CLMUL, 32'h3, 32'h3, 5'd11);
        flush = 1'b1;
        in_valid = 1'b1; in_rs1 = 32'h5; in_rs2 = 32'h5; in_tag = 5'd12;
        #1;
        chk("fl_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_busy", 32'(busy), 32'd0);
        chk("fl_valid", 32'(out_valid), 32'd0);
        tick();
        chk("fl_valid2", 32'(out_valid), 32'd0);
        chk("fl_busy2", 32'(busy), 32'd0);

        // Async reset while a result is waiting.
        issue(CLMULH, 32'h8000_0000, 32'h8000_0000, 5'd13);
        tick();
        chk("rd_valid_pre", 32'(out_valid), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("rd_valid", 32'(out_valid), 32'd0);
        chk("rd_data", out_data, 32'd0);
        chk("rd_tag", 32'(out_tag), 32'd0);
        chk("rd_busy", 32'(busy), 32'd0);
        chk("rd_ready", 32'(in_ready), 32'd1);
        @(negedge CLK);
        nRST = 1'b1;
        tick();

        // Zero operand: latency depends on the shortcut build option.
        issue(CLMULH, 32'h0, 32'hFFFF_FFFF, 5'd14);
`ifdef ZBC_ZERO_SHORTCUT_EN
        chk("z_valid", 32'(out_valid), 32'd1);
        chk("z_data", out_data, 32'd0);
        chk("z_tag", 32'(out_tag), 32'd14);
`else
        chk("z_mul_valid", 32'(out_valid), 32'd0);
        tick();
        chk("z_valid", 32'(out_valid), 32'd1);
        chk("z_data", out_data, 32'd0);
        chk("z_tag", 32'(out_tag), 32'd14);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        // Following non-zero op must not inherit a zero result.
        run_op("post_z", CLMUL, 32'h3, 32'h3, 5'd15, 32'h0000_0005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
